// File: rtl/axis_count_check.sv
// Sink and sequence checker for an incrementing AXI Stream count source.
// Locks onto the first accepted value, then expects previous + 1 and keeps debug statistics.
module axis_count_check #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_TDATA,
  input  logic              in_TVALID,
  output logic              in_TREADY,
  output logic              synced,
  output logic [31:0]       beat_count,
  output logic [15:0]       err_count,
  output logic              err,
  output logic [WIDTH-1:0]  last_bad_got,
  output logic [WIDTH-1:0]  last_bad_exp
);

  localparam int unsigned BEAT_W = 32;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned CNT_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               stall_hit_c;
  logic               accept_c;
  logic               lock_c;
  logic               mismatch_c;
  logic [WIDTH-1:0]   exp_q;
  logic [WIDTH-1:0]   next_exp_c;

  // A period of one would hold TREADY low forever.
  if (STALL_PERIOD == 1) begin : g_bad_period
    $error("axis_count_check: STALL_PERIOD must be 0 or at least 2");
  end

  // Free-running backpressure counter; its last slot drops TREADY for one cycle.
  if (STALL_PERIOD == 0) begin : g_no_stall
    assign stall_hit_c = 1'b0;
  end else begin : g_stall
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        stall_cnt <= '0;
      end else if (stall_cnt == CNT_W'(STALL_PERIOD - 1)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end

    assign stall_hit_c = (stall_cnt == CNT_W'(STALL_PERIOD - 1));
  end

  // Ready never looks at TVALID, so the handshake stays AXI-compliant.
  assign in_TREADY  = !rst && !stall_hit_c;
  assign accept_c   = in_TVALID && in_TREADY;
  assign next_exp_c = WIDTH'(in_TDATA + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (accept_c) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = SYNC;
    endcase
  end

  // Beat classification: the first beat only locks, later beats are compared.
  always_comb begin
    lock_c     = 1'b0;
    mismatch_c = 1'b0;
    case (state_q)
      SYNC:    lock_c     = accept_c;
      TRACK:   mismatch_c = accept_c && (in_TDATA != exp_q);
      default: lock_c     = 1'b0;
    endcase
  end

  // Every accepted beat re-seeds exp from its own data, so a gap costs one error.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q        <= '0;
      synced       <= 1'b0;
      beat_count   <= '0;
      err_count    <= '0;
      err          <= 1'b0;
      last_bad_got <= '0;
      last_bad_exp <= '0;
    end else if (accept_c) begin
      exp_q <= next_exp_c;
      if (beat_count != {BEAT_W{1'b1}}) begin
        beat_count <= beat_count + BEAT_W'(1);
      end
      if (lock_c) begin
        synced <= 1'b1;
      end
      if (mismatch_c) begin
        err          <= 1'b1;
        last_bad_got <= in_TDATA;
        last_bad_exp <= exp_q;
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_count_check.sv
// Self-checking bench for axis_count_check: one instance without backpressure,
// one with STALL_PERIOD=4; a reference model feeds a scoreboard queue.
module tb_axis_count_check;

  typedef struct {
    logic        synced;
    logic [31:0] beats;
    logic [15:0] errs;
    logic        err;
    logic [31:0] got;
    logic [31:0] expv;
  } status_t;

  typedef struct {
    logic [31:0] data;
    status_t     st;
  } vec_t;

  logic        clk;
  logic        rst;

  logic [31:0] tdata0;
  logic        tvalid0;
  logic        ready0;
  logic        synced0;
  logic [31:0] beats0;
  logic [15:0] errs0;
  logic        err0;
  logic [31:0] got0;
  logic [31:0] expv0;

  logic [31:0] tdata4;
  logic        tvalid4;
  logic        ready4;
  logic        synced4;
  logic [31:0] beats4;
  logic [15:0] errs4;
  logic        err4;
  logic [31:0] got4;
  logic [31:0] expv4;

  int n_checks;
  int n_fail;

  status_t     sb[$];
  status_t     m;
  logic [31:0] m_exp;

  axis_count_check #(.WIDTH(32), .STALL_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_TDATA(tdata0), .in_TVALID(tvalid0), .in_TREADY(ready0),
    .synced(synced0), .beat_count(beats0), .err_count(errs0), .err(err0),
    .last_bad_got(got0), .last_bad_exp(expv0)
  );

  axis_count_check #(.WIDTH(32), .STALL_PERIOD(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_TDATA(tdata4), .in_TVALID(tvalid4), .in_TREADY(ready4),
    .synced(synced4), .beat_count(beats4), .err_count(errs4), .err(err4),
    .last_bad_got(got4), .last_bad_exp(expv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic chk_status(input string tag, input status_t s);
    chk({tag, ".synced"}, 32'(synced0), 32'(s.synced));
    chk({tag, ".beat_count"}, beats0, s.beats);
    chk({tag, ".err_count"}, 32'(errs0), 32'(s.errs));
    chk({tag, ".err"}, 32'(err0), 32'(s.err));
    chk({tag, ".last_bad_got"}, got0, s.got);
    chk({tag, ".last_bad_exp"}, expv0, s.expv);
  endtask

  task automatic model_reset();
    m = '{synced: 1'b0, beats: 32'd0, errs: 16'd0, err: 1'b0, got: 32'd0, expv: 32'd0};
    m_exp = 32'd0;
  endtask

  task automatic model_beat(input logic [31:0] d);
    if (!m.synced) begin
      m.synced = 1'b1;
    end else if (d != m_exp) begin
      if (m.errs != 16'hFFFF) m.errs = m.errs + 16'd1;
      m.err  = 1'b1;
      m.got  = d;
      m.expv = m_exp;
    end
    if (m.beats != 32'hFFFF_FFFF) m.beats = m.beats + 32'd1;
    m_exp = d + 32'd1;
  endtask

  // Called at a falling edge; returns at the falling edge with rst released.
  task automatic reset_all(input logic valid_in_reset);
    status_t zero;
    zero = '{synced: 1'b0, beats: 32'd0, errs: 16'd0, err: 1'b0, got: 32'd0, expv: 32'd0};
    rst     = 1'b1;
    tvalid0 = valid_in_reset;
    tdata0  = 32'h0000_0099;
    tvalid4 = 1'b0;
    #1;
    chk("ready0_in_reset", 32'(ready0), 32'd0);
    chk("ready4_in_reset", 32'(ready4), 32'd0);
    @(posedge clk);
    #1;
    chk_status("reset", zero);
    chk("beat4_reset", beats4, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    tvalid0 = 1'b0;
    sb.delete();
    model_reset();
  endtask

  // Drive one beat into dut0 (always ready) and score it after the edge.
  task automatic beat0(input logic [31:0] d);
    status_t s;
    tvalid0 = 1'b1;
    tdata0  = d;
    #1;
    chk("ready0", 32'(ready0), 32'd1);
    model_beat(d);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      s = sb.pop_front();
      chk_status($sformatf("beat_%08h", d), s);
    end
    @(negedge clk);
  endtask

  task automatic idle0(input int cycles);
    tvalid0 = 1'b0;
    tdata0  = $urandom;
    repeat (cycles) @(posedge clk);
    #1;
    chk_status("idle", m);
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    tvalid0  = 1'b0;
    tdata0   = '0;
    tvalid4  = 1'b0;
    tdata4   = '0;
    model_reset();

    tbl[0] = '{32'd0, '{1'b1, 32'd1, 16'd0, 1'b0, 32'd0, 32'd0}};
    tbl[1] = '{32'd1, '{1'b1, 32'd2, 16'd0, 1'b0, 32'd0, 32'd0}};
    tbl[2] = '{32'd2, '{1'b1, 32'd3, 16'd0, 1'b0, 32'd0, 32'd0}};
    tbl[3] = '{32'd4, '{1'b1, 32'd4, 16'd1, 1'b1, 32'd4, 32'd3}};
    tbl[4] = '{32'd5, '{1'b1, 32'd5, 16'd1, 1'b1, 32'd4, 32'd3}};
    tbl[5] = '{32'd6, '{1'b1, 32'd6, 16'd1, 1'b1, 32'd4, 32'd3}};

    @(negedge clk);
    reset_all(1'b1);

    // Counting 0..99 back to back.
    #1;
    chk("synced_before_first", 32'(synced0), 32'd0);
    for (int i = 0; i < 100; i++) beat0(32'(i));
    chk("count100_beats", beats0, 32'd100);
    chk("count100_errs", 32'(errs0), 32'd0);
    chk("count100_err", 32'(err0), 32'd0);
    idle0(3);

    // Arbitrary start value.
    reset_all(1'b0);
    for (int i = 0; i < 10; i++) beat0(32'h0000_1234 + 32'(i));
    chk("start1234_beats", beats0, 32'd10);
    chk("start1234_err", 32'(err0), 32'd0);

    // Single gap, table-driven.
    reset_all(1'b0);
    for (int i = 0; i < 6; i++) begin
      tvalid0 = 1'b1;
      tdata0  = tbl[i].data;
      @(posedge clk);
      #1;
      chk_status($sformatf("gap_vec%0d", i), tbl[i].st);
      @(negedge clk);
    end
    tvalid0 = 1'b0;

    // Wrap-around is clean; then a skip right after it.
    reset_all(1'b0);
    beat0(32'hFFFF_FFFE);
    beat0(32'hFFFF_FFFF);
    beat0(32'h0000_0000);
    beat0(32'h0000_0001);
    chk("wrap_errs", 32'(errs0), 32'd0);
    beat0(32'h0000_0003);
    chk("wrap_skip_exp", expv0, 32'h0000_0002);
    chk("wrap_skip_got", got0, 32'h0000_0003);
    tvalid0 = 1'b0;

    // Three errors, then reset mid-stream with TVALID high and resync.
    reset_all(1'b0);
    beat0(32'd0);
    beat0(32'd5);
    beat0(32'd10);
    beat0(32'd15);
    chk("pre_reset_errs", 32'(errs0), 32'd3);
    reset_all(1'b1);
    beat0(32'h0000_0050);
    beat0(32'h0000_0051);
    chk("post_reset_errs", 32'(errs0), 32'd0);
    chk("post_reset_err", 32'(err0), 32'd0);
    chk("post_reset_beats", beats0, 32'd2);
    chk("post_reset_synced", 32'(synced0), 32'd1);
    tvalid0 = 1'b0;

    // Backpressure 1,1,1,0 with a compliant source on dut4.
    reset_all(1'b0);
    begin
      logic [31:0] d;
      logic        acc;
      d       = 32'h0000_0700;
      tvalid4 = 1'b1;
      tdata4  = d;
      for (int i = 0; i < 100; i++) begin
        #1;
        chk($sformatf("ready4_cycle%0d", i), 32'(ready4), (i % 4 == 3) ? 32'd0 : 32'd1);
        acc = ready4;
        @(posedge clk);
        if (acc) d = d + 32'd1;
        @(negedge clk);
        tdata4 = d;
      end
      tvalid4 = 1'b0;
      #1;
      chk("stall_beats", beats4, 32'd75);
      chk("stall_errs", 32'(errs4), 32'd0);
      chk("stall_err", 32'(err4), 32'd0);
      chk("stall_synced", 32'(synced4), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_count_check.md
# axis_count_check

Sink and checker for a 32-bit incrementing AXI Stream count source. It accepts beats under a programmable backpressure pattern and locks onto the first value it receives. Every later beat is checked against previous value + 1, and the block keeps beat and error statistics for the debug/demo fabric.

## Interface
- WIDTH, 32, data width; expected value arithmetic is modulo 2^WIDTH
- STALL_PERIOD, 0, backpressure period; 0 = TREADY always high; N ≥ 2 = TREADY low 1 cycle in every N; 1 is illegal (elaboration error)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_TDATA  in  WIDTH  stream data
- in_TVALID  in  1  stream valid
- in_TREADY  out  1  stream ready
- synced  out  1  high once the first beat after reset has been accepted
- beat_count  out  32  accepted beats, saturates at 0xFFFFFFFF
- err_count  out  16  sequence mismatches, saturates at 0xFFFF
- err  out  1  sticky: set on the first mismatch, cleared only by rst
- last_bad_got  out  WIDTH  TDATA of the most recent mismatching beat
- last_bad_exp  out  WIDTH  expected value at the most recent mismatch

## Operation
- Handshake: a beat is accepted in a cycle where in_TVALID && in_TREADY. Non-accepted cycles change no statistics. TDATA is sampled only on acceptance.
- Ready generator: stall_cnt is a free-running counter, 0..STALL_PERIOD-1. It wraps and runs regardless of TVALID.
  - in_TREADY = !rst && (STALL_PERIOD == 0 || stall_cnt != STALL_PERIOD-1).
- The checker has two states, SYNC and TRACK. Reset enters SYNC.
- SYNC, on acceptance:
  - exp <= TDATA + 1; synced <= 1; beat_count increments; go to TRACK.
  - No comparison is made, so any start value is legal.
- TRACK, on acceptance with TDATA == exp: exp <= exp + 1; beat_count increments.
- TRACK, on acceptance with TDATA != exp:
  - err_count increments (saturating); err <= 1.
  - last_bad_got <= TDATA; last_bad_exp <= exp.
  - exp <= TDATA + 1, i.e. resync. A single gap therefore counts exactly one error, not a cascade.
  - beat_count still increments.
- Wrap-around: exp after all-ones is 0. The sequence …FFFFFFFE, FFFFFFFF, 00000000 is error-free.
- Saturation: the counters hold at their maximum. err still sets, and the capture registers still update on mismatches past saturation.
- Reset behaviour:
  - Reset mid-stream discards state and returns to SYNC.
  - in_TREADY is low during any cycle with rst high, so no beat is accepted in the reset cycle.

## Timing
- Reset values: synced 0, beat_count 0, err_count 0, err 0, last_bad_got 0, last_bad_exp 0, stall_cnt 0, internal exp 0, state SYNC.
- All status outputs are registered. Effects of a beat accepted on edge k are visible after edge k (one-cycle latency).
- in_TREADY is combinational from rst and stall_cnt only, never from TVALID, which keeps it AXI-compliant. It is high in the first cycle after rst deasserts when STALL_PERIOD ≠ 0.
- With STALL_PERIOD = N and TVALID held high, exactly N-1 beats are accepted per N cycles.
- Simultaneous mismatch and saturated err_count: err_count holds; all other mismatch effects proceed.
- Source must hold TDATA stable while TVALID && !TREADY. The checker does not police this.

## Test plan
- STALL_PERIOD=0, TVALID high, data 0..99 over 100 cycles -> synced=1 one cycle after the first beat; beat_count=100; err_count=0; err=0.
- Start value 0x00001234, then sequential for 10 beats -> no error; beat_count=10.
- Sequence 0,1,2,4,5,6 -> err_count=1, err=1, last_bad_got=4, last_bad_exp=3; beats 5 and 6 clean; beat_count=6.
- Wrap: 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 -> err_count=0. Then send 0x3 -> last_bad_exp=0x2.
- STALL_PERIOD=4, TVALID always high, source obeys backpressure for 100 cycles -> TREADY pattern 1,1,1,0 repeating; beat_count=75; err_count=0.
- Reset mid-stream after 3 errors, rst for 1 cycle, then send 0x50, 0x51 -> outputs read 0 during reset; TREADY 0 in the rst cycle; resync on 0x50 with no error; err_count=0; beat_count=2.
